// File: rtl/led_axil_arbiter_if.sv
// Bundle of the two requester command ports and the AXI4-Lite master channels.
// The arbiter uses the master modport; requesters and the AXI slave sit on the slave side.
interface led_axil_arbiter_if #(
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_DATA_WIDTH = 32
);
  localparam int unsigned IdxW = C_ADDR_WIDTH - 2;

  logic                      req0_valid;
  logic                      req0_we;
  logic [IdxW-1:0]           req0_idx;
  logic [C_DATA_WIDTH-1:0]   req0_wdata;
  logic                      req0_ack;
  logic [C_DATA_WIDTH-1:0]   req0_rdata;
  logic [1:0]                req0_resp;

  logic                      req1_valid;
  logic                      req1_we;
  logic [IdxW-1:0]           req1_idx;
  logic [C_DATA_WIDTH-1:0]   req1_wdata;
  logic                      req1_ack;
  logic [C_DATA_WIDTH-1:0]   req1_rdata;
  logic [1:0]                req1_resp;

  logic [C_ADDR_WIDTH-1:0]   m_awaddr;
  logic [2:0]                m_awprot;
  logic                      m_awvalid;
  logic                      m_awready;
  logic [C_DATA_WIDTH-1:0]   m_wdata;
  logic [C_DATA_WIDTH/8-1:0] m_wstrb;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [1:0]                m_bresp;
  logic                      m_bvalid;
  logic                      m_bready;
  logic [C_ADDR_WIDTH-1:0]   m_araddr;
  logic [2:0]                m_arprot;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [C_DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rvalid;
  logic                      m_rready;

  modport master (
    input  req0_valid, req0_we, req0_idx, req0_wdata,
    output req0_ack, req0_rdata, req0_resp,
    input  req1_valid, req1_we, req1_idx, req1_wdata,
    output req1_ack, req1_rdata, req1_resp,
    output m_awaddr, m_awprot, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arprot, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    output req0_valid, req0_we, req0_idx, req0_wdata,
    input  req0_ack, req0_rdata, req0_resp,
    output req1_valid, req1_we, req1_idx, req1_wdata,
    input  req1_ack, req1_rdata, req1_resp,
    input  m_awaddr, m_awprot, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arprot, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/led_axil_arbiter.sv
// Round-robin two-requester sequencer in front of the LED IP AXI4-Lite register file.
// One single-word AXI4-Lite transaction at a time; all outputs registered.
module led_axil_arbiter #(
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  led_axil_arbiter_if.master     bus,
  output logic [7:0]             ERR_CNT
);
  localparam int unsigned IdxW = C_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gnt_q, gnt_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    ack0_q, ack0_d, ack1_q, ack1_d;
  logic [C_DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]              resp0_q, resp0_d, resp1_q, resp1_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  // Requester selection: alternate on contention, otherwise take whoever asks.
  logic                    sel;
  logic                    sel_we;
  logic [IdxW-1:0]         sel_idx;
  logic [C_DATA_WIDTH-1:0] sel_wdata;

  assign sel       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign sel_we    = sel ? bus.req1_we    : bus.req0_we;
  assign sel_idx   = sel ? bus.req1_idx   : bus.req0_idx;
  assign sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;

  logic                    fin;
  logic                    fin_rd;
  logic [1:0]              fin_resp;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    resp0_d      = resp0_q;
    resp1_d      = resp1_q;
    err_cnt_d    = err_cnt_q;
    fin          = 1'b0;
    fin_rd       = 1'b0;
    fin_resp     = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (bus.req0_valid || bus.req1_valid) begin
          gnt_d        = sel;
          last_grant_d = sel;
          if (sel_we) begin
            awaddr_d  = {sel_idx, 2'b00};
            wdata_d   = sel_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            araddr_d  = {sel_idx, 2'b00};
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        // AW and W complete independently, in any order.
        awvalid_d = awvalid_q && !bus.m_awready;
        wvalid_d  = wvalid_q && !bus.m_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (bus.m_bvalid) begin
          bready_d = 1'b0;
          fin      = 1'b1;
          fin_resp = bus.m_bresp;
          state_d  = StDone;
        end
      end
      StRdReq: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end
      end
      StRdResp: begin
        if (bus.m_rvalid) begin
          rready_d = 1'b0;
          fin      = 1'b1;
          fin_rd   = 1'b1;
          fin_resp = bus.m_rresp;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Results are registered on entry to StDone so they line up with the ack pulse.
    if (fin) begin
      if (gnt_q) begin
        ack1_d  = 1'b1;
        resp1_d = fin_resp;
        if (fin_rd) rdata1_d = bus.m_rdata;
      end else begin
        ack0_d  = 1'b1;
        resp0_d = fin_resp;
        if (fin_rd) rdata0_d = bus.m_rdata;
      end
      if (fin_resp != 2'b00 && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      resp0_q      <= 2'b00;
      resp1_q      <= 2'b00;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      resp0_q      <= resp0_d;
      resp1_q      <= resp1_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.m_awaddr   = awaddr_q;
  assign bus.m_awprot   = 3'b000;
  assign bus.m_awvalid  = awvalid_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.m_wstrb    = '1;
  assign bus.m_wvalid   = wvalid_q;
  assign bus.m_bready   = bready_q;
  assign bus.m_araddr   = araddr_q;
  assign bus.m_arprot   = 3'b000;
  assign bus.m_arvalid  = arvalid_q;
  assign bus.m_rready   = rready_q;
  assign bus.req0_ack   = ack0_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req0_resp  = resp0_q;
  assign bus.req1_ack   = ack1_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.req1_resp  = resp1_q;
  assign ERR_CNT        = err_cnt_q;
endmodule

// File: tb/tb_led_axil_arbiter.sv
// Directed bench for led_axil_arbiter: AXI4-Lite slave model with injectable stalls/errors,
// per-requester expectation queues popped on each ack.
module tb_led_axil_arbiter;
  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [7:0] ERR_CNT;

  led_axil_arbiter_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) bus ();

  led_axil_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bus     (bus),
    .ERR_CNT (ERR_CNT)
  );

  always #5 ACLK = ~ACLK;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  int          aw_delay = 0, w_delay = 0, aw_wait, w_wait, b_count;
  bit          b_hold = 1'b0, err_mode = 1'b0;
  logic        s_have_aw, s_have_w;
  logic [1:0]  s_widx;
  logic [31:0] s_wdat;
  logic [31:0] s_mem [4];

  assign bus.m_awready = bus.m_awvalid && (aw_wait >= aw_delay);
  assign bus.m_wready  = bus.m_wvalid && (w_wait >= w_delay);
  assign bus.m_arready = bus.m_arvalid;

  wire        aw_hs   = bus.m_awvalid & bus.m_awready;
  wire        w_hs    = bus.m_wvalid & bus.m_wready;
  wire        got_aw  = s_have_aw | aw_hs;
  wire        got_w   = s_have_w | w_hs;
  wire [1:0]  eff_idx = aw_hs ? bus.m_awaddr[3:2] : s_widx;
  wire [31:0] eff_dat = w_hs ? bus.m_wdata : s_wdat;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; b_count <= 0;
      s_have_aw <= 1'b0; s_have_w <= 1'b0; s_widx <= 2'd0; s_wdat <= 32'd0;
      for (int i = 0; i < 4; i++) s_mem[i] <= 32'd0;
      bus.m_bvalid <= 1'b0; bus.m_bresp <= 2'b00;
      bus.m_rvalid <= 1'b0; bus.m_rresp <= 2'b00; bus.m_rdata <= 32'd0;
    end else begin
      aw_wait <= (bus.m_awvalid && !bus.m_awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.m_wvalid && !bus.m_wready) ? w_wait + 1 : 0;
      if (bus.m_bvalid && bus.m_bready) begin
        bus.m_bvalid <= 1'b0;
        b_count      <= b_count + 1;
      end
      if (got_aw && got_w && !b_hold && !bus.m_bvalid) begin
        s_mem[eff_idx] <= eff_dat;
        bus.m_bvalid   <= 1'b1;
        bus.m_bresp    <= 2'b00;
        s_have_aw      <= 1'b0;
        s_have_w       <= 1'b0;
      end else begin
        if (aw_hs) begin s_have_aw <= 1'b1; s_widx <= bus.m_awaddr[3:2]; end
        if (w_hs)  begin s_have_w <= 1'b1;  s_wdat <= bus.m_wdata; end
      end
      if (bus.m_arvalid && bus.m_arready) begin
        bus.m_rvalid <= 1'b1;
        bus.m_rdata  <= s_mem[bus.m_araddr[3:2]];
        bus.m_rresp  <= err_mode ? 2'b10 : 2'b00;
      end else if (bus.m_rvalid && bus.m_rready) begin
        bus.m_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        mon_e;
  bit          ack_log[$];
  logic [31:0] model_mem [4];
  logic [31:0] last_rd [2];

  always @(negedge ACLK) begin
    if (bus.req0_ack === 1'b1) begin
      ack_log.push_back(1'b0);
      if (q0.size() == 0) check("ack0_unexpected", 32'(bus.req0_ack), 32'd0);
      else begin
        mon_e = q0.pop_front();
        check("rdata0", bus.req0_rdata, mon_e.rdata);
        check("resp0", 32'(bus.req0_resp), 32'(mon_e.resp));
      end
    end
    if (bus.req1_ack === 1'b1) begin
      ack_log.push_back(1'b1);
      if (q1.size() == 0) check("ack1_unexpected", 32'(bus.req1_ack), 32'd0);
      else begin
        mon_e = q1.pop_front();
        check("rdata1", bus.req1_rdata, mon_e.rdata);
        check("resp1", 32'(bus.req1_resp), 32'(mon_e.resp));
      end
    end
  end

  // A VALID must drop in the cycle right after its own handshake.
  logic aw_hs_prev = 1'b0, w_hs_prev = 1'b0, ar_hs_prev = 1'b0;
  always @(negedge ACLK) begin
    if (aw_hs_prev) check("awvalid_drop", 32'(bus.m_awvalid), 32'd0);
    if (w_hs_prev)  check("wvalid_drop", 32'(bus.m_wvalid), 32'd0);
    if (ar_hs_prev) check("arvalid_drop", 32'(bus.m_arvalid), 32'd0);
    aw_hs_prev <= aw_hs & ~ARESET;
    w_hs_prev  <= w_hs & ~ARESET;
    ar_hs_prev <= bus.m_arvalid & bus.m_arready & ~ARESET;
  end

  // Called just after a rising edge; returns one cycle after the ack with VALID low.
  task automatic req_txn(input bit p, input bit we, input logic [1:0] idx,
                         input logic [31:0] wd, input bit chk_lat);
    exp_t e;
    int   n;
    logic ack;
    e.rdata = we ? last_rd[p] : model_mem[idx];
    e.resp  = (!we && err_mode) ? 2'b10 : 2'b00;
    if (we) model_mem[idx] = wd;
    else    last_rd[p] = model_mem[idx];
    if (p) begin
      q1.push_back(e);
      bus.req1_we = we; bus.req1_idx = idx; bus.req1_wdata = wd; bus.req1_valid = 1'b1;
    end else begin
      q0.push_back(e);
      bus.req0_we = we; bus.req0_idx = idx; bus.req0_wdata = wd; bus.req0_valid = 1'b1;
    end
    n = 0;
    do begin
      @(posedge ACLK); #1;
      n++;
      ack = p ? bus.req1_ack : bus.req0_ack;
    end while (ack !== 1'b1 && n < 60);
    check(p ? "ack1_seen" : "ack0_seen", 32'(ack), 32'd1);
    if (chk_lat) check("ack_latency", 32'(n), 32'd3);
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
    @(posedge ACLK); #1;
  endtask

  initial begin
    int n;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_idx = 2'd0; bus.req0_wdata = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_idx = 2'd0; bus.req1_wdata = 32'd0;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'd0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;

    check("rst_awvalid", 32'(bus.m_awvalid), 32'd0);
    check("rst_wvalid", 32'(bus.m_wvalid), 32'd0);
    check("rst_bready", 32'(bus.m_bready), 32'd0);
    check("rst_arvalid", 32'(bus.m_arvalid), 32'd0);
    check("rst_rready", 32'(bus.m_rready), 32'd0);
    check("rst_awaddr", 32'(bus.m_awaddr), 32'd0);
    check("rst_araddr", 32'(bus.m_araddr), 32'd0);
    check("rst_wdata", bus.m_wdata, 32'd0);
    check("rst_ack0", 32'(bus.req0_ack), 32'd0);
    check("rst_ack1", 32'(bus.req1_ack), 32'd0);
    check("rst_rdata0", bus.req0_rdata, 32'd0);
    check("rst_rdata1", bus.req1_rdata, 32'd0);
    check("rst_resp0", 32'(bus.req0_resp), 32'd0);
    check("rst_resp1", 32'(bus.req1_resp), 32'd0);
    check("rst_err_cnt", 32'(ERR_CNT), 32'd0);

    // Contention straight out of reset: requester 0 wins first, then strict alternation.
    ack_log.delete();
    fork
      begin for (int i = 0; i < 4; i++) req_txn(1'b0, 1'b1, 2'd1, 32'hA5, 1'b0); end
      begin for (int i = 0; i < 4; i++) req_txn(1'b1, 1'b1, 2'd2, 32'h5A, 1'b0); end
    join
    check("contention_acks", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) check("grant_order", 32'(ack_log[i]), 32'(i % 2));
    req_txn(1'b0, 1'b0, 2'd1, 32'd0, 1'b1);
    req_txn(1'b1, 1'b0, 2'd2, 32'd0, 1'b1);

    // Sequential writes then reads with a zero-wait slave.
    for (int i = 0; i < 4; i++) req_txn(1'b0, 1'b1, 2'(i), 32'(i + 1), 1'b1);
    for (int i = 0; i < 4; i++) req_txn(1'b0, 1'b0, 2'(i), 32'd0, 1'b1);

    // Backpressure on one write channel, then the other.
    n = b_count;
    aw_delay = 3; w_delay = 0;
    req_txn(1'b0, 1'b1, 2'd2, 32'h11, 1'b0);
    check("bp_aw_bcount", 32'(b_count - n), 32'd1);
    check("bp_aw_mem", s_mem[2], 32'h11);
    n = b_count;
    aw_delay = 0; w_delay = 3;
    req_txn(1'b0, 1'b1, 2'd3, 32'h22, 1'b0);
    check("bp_w_bcount", 32'(b_count - n), 32'd1);
    check("bp_w_mem", s_mem[3], 32'h22);
    w_delay = 0;
    req_txn(1'b0, 1'b0, 2'd2, 32'd0, 1'b1);
    req_txn(1'b1, 1'b0, 2'd3, 32'd0, 1'b1);

    // SLVERR on every read; error counter saturates.
    check("err_cnt_pre", 32'(ERR_CNT), 32'd0);
    err_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req_txn(1'(i % 2), 1'b0, 2'(i % 4), 32'd0, 1'b0);
      check("err_cnt", 32'(ERR_CNT), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    err_mode = 1'b0;

    // Reset while waiting for the write response.
    b_hold = 1'b1;
    bus.req0_we = 1'b1; bus.req0_idx = 2'd0; bus.req0_wdata = 32'h77; bus.req0_valid = 1'b1;
    n = 0;
    do begin @(posedge ACLK); #1; n++; end while (bus.m_bready !== 1'b1 && n < 20);
    check("mid_in_wr_resp", 32'(bus.m_bready), 32'd1);
    ARESET = 1'b1; bus.req0_valid = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0; b_hold = 1'b0;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'd0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    check("mid_awvalid", 32'(bus.m_awvalid), 32'd0);
    check("mid_wvalid", 32'(bus.m_wvalid), 32'd0);
    check("mid_bready", 32'(bus.m_bready), 32'd0);
    check("mid_arvalid", 32'(bus.m_arvalid), 32'd0);
    check("mid_rready", 32'(bus.m_rready), 32'd0);
    check("mid_ack0", 32'(bus.req0_ack), 32'd0);
    check("mid_ack1", 32'(bus.req1_ack), 32'd0);
    check("mid_err_cnt", 32'(ERR_CNT), 32'd0);
    check("mid_rdata0", bus.req0_rdata, 32'd0);
    req_txn(1'b1, 1'b1, 2'd3, 32'h3, 1'b1);
    req_txn(1'b1, 1'b0, 2'd3, 32'd0, 1'b1);

    repeat (3) @(posedge ACLK);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
